bubsysrom_ioctl_loader: RTL and testbench
=========================================

// Module: bubsysrom_ioctl_loader
// PURPOSE
//  Receives the HPS ioctl ROM download byte stream and forwards it into SDRAM.
//  Packs bytes into big-endian 16-bit words for the 68k and buffers them in a small FIFO.
//  Issues req/ack word writes to the SDRAM controller and throttles the HPS with o_IOCTL_WAIT.
//  Sits between the MiSTer ioctl bus and the SDRAM write port of BubSysROM_emu.
// PARAMETERS
//  ROM_INDEX   16'h0000  ioctl_index value this loader accepts; other indices are ignored
//  BASE_WADDR  24'h0     SDRAM word address that ioctl byte address 0 maps to
//  FIFO_DEPTH  8         word FIFO entries; power of two, >=4
// PORTS
//  i_EMU_MCLK         in   1   core clock; ioctl and SDRAM ports are in this domain
//  i_EMU_RST_n        in   1   asynchronous active-low reset
//  i_IOCTL_INDEX      in   16  download index
//  i_IOCTL_DOWNLOAD   in   1   download session active
//  i_IOCTL_ADDR       in   27  byte address
//  i_IOCTL_DATA       in   8   byte data
//  i_IOCTL_WR         in   1   byte strobe, 1 cycle per byte
//  o_IOCTL_WAIT       out  1   stall request to HPS
//  o_SDRAM_WR_REQ     out  1   write request (level)
//  o_SDRAM_WR_ADDR    out  24  word address
//  o_SDRAM_WR_DATA    out  16  {even byte, odd byte}
//  o_SDRAM_WR_BE      out  2   byte enables {hi,lo}
//  i_SDRAM_WR_ACK     in   1   one-cycle write-complete pulse
//  o_DOWNLOAD_DONE    out  1   ROM fully written to SDRAM
//  o_OVERFLOW         out  1   sticky: byte arrived with FIFO full and was dropped
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, holding register invalid, FSM IDLE. A reset mid-download aborts everything; an outstanding req is dropped without waiting for ack.
//  Session FSM: IDLE -> LOAD on rising edge of DOWNLOAD with INDEX==ROM_INDEX; DONE and OVERFLOW clear on entry.
//   LOAD -> DRAIN on falling edge of DOWNLOAD. DRAIN -> DONE once held flushed, FIFO empty, no req.
//   DONE -> LOAD on next matching rising edge. A non-matching index never leaves IDLE/DONE; WAIT stays 0.
//  Byte accept (LOAD only, i_IOCTL_WR=1): waddr = BASE_WADDR + ADDR[24:1] (24-bit wrap).
//   Holding reg {waddr,data,be}. If held valid and waddr differs: push held, load new byte.
//   Else merge byte (ADDR[0]=0 -> hi/be[1], 1 -> lo/be[0]); if be becomes 2'b11, push merged and invalidate held.
//   A byte whose lane is already enabled at the same waddr overwrites that lane.
//   At most one FIFO push per cycle by construction.
//  DRAIN entry: held valid -> one extra push (partial BE) before FIFO drains.
//  Flow control: o_IOCTL_WAIT registered, high when free FIFO slots <=2 or a DRAIN flush is pending.
//   The 2-slot margin absorbs one-cycle WAIT latency. A byte arriving with FIFO full is dropped and sets OVERFLOW.
//  SDRAM side, writer FSM: W_IDLE -> W_REQ when FIFO is non-empty. Head entry goes to ADDR/DATA/BE, REQ=1.
//   ADDR/DATA/BE are held stable until ACK. ACK pops the entry; REQ=0 in the cycle after ACK (min 1 low cycle).
//   ACK while REQ=0 is ignored. Push and pop in the same cycle keep the count unchanged.
//  Latency: a completing odd byte produces REQ 2 cycles later when the FIFO is empty (push, then register).
//  DONE stays high until the next matching session starts or reset.
// STRUCTURE
//  Shared include bubsysrom_loader_defs.vh: ioctl widths, SDRAM word-address width, BE constants,
//   session states (IDLE/LOAD/DRAIN/DONE) and writer states (W_IDLE/W_REQ).
//  Sub-module bubsysrom_loader_fifo: synchronous FIFO, {24+16+2} bits wide, FIFO_DEPTH entries.
//   Ports: push, pop, full, empty and free count.
//  Top level contains the holding register, address map, both FSMs and the WAIT/OVERFLOW logic.
// TESTING
//  1 Index 0, bytes 12,34,56,78 at addr 0..3, ACK 3 cycles after REQ -> writes (0,1234,11),(1,5678,11); DONE after last ACK.
//  2 BASE_WADDR=24'h100000, odd count: bytes AA,BB,CC at addr 0..2 -> (100000,AABB,11),(100001,CC00,10) at DRAIN.
//  3 ACK held off 40 cycles, bytes streamed every cycle -> WAIT rises at 2 free slots.
//     No OVERFLOW, no lost word; writes are in-order after ACK resumes.
//  4 Index 1 download with ROM_INDEX=0 -> no REQ, WAIT=0, DONE unchanged.
//  5 Non-sequential: byte 11 at addr 5, then 22 at addr 8 -> (2,0011,01) then (4,2200,10).
//  6 Reset pulse with REQ high mid-download -> all outputs 0 next edge; a new session loads cleanly.

Source files
------------

// File: rtl/bubsysrom_ioctl_loader_pkg.sv
// Shared definitions for the BubSysROM ioctl ROM loader.
//  - ioctl bus widths, SDRAM word-address/data widths
//  - byte-enable constants ({hi,lo} lanes of a big-endian 68k word)
//  - session FSM states (IDLE/LOAD/DRAIN/DONE) and writer FSM states (W_IDLE/W_REQ)
//  - the word entry carried through the holding register and the FIFO
package bubsysrom_ioctl_loader_pkg;

   localparam int IOCTL_INDEX_W = 16;
   localparam int IOCTL_ADDR_W  = 27;
   localparam int IOCTL_DATA_W  = 8;
   localparam int WADDR_W       = 24;
   localparam int WDATA_W       = 16;

   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_BOTH = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } session_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_REQ  = 1'b1
   } writer_e;

   typedef struct packed {
      logic [WADDR_W-1:0] addr;
      logic [WDATA_W-1:0] data;
      logic [1:0]         be;
   } wentry_t;

   localparam int WENTRY_W = $bits(wentry_t);

   // Drop one byte into its lane: even byte addresses are the high (first) byte of
   // the 68k word, odd ones the low byte. An already-enabled lane is overwritten.
   function automatic wentry_t lane_merge(input wentry_t e, input logic [IOCTL_DATA_W-1:0] b,
                                          input logic odd);
      wentry_t r;
      r = e;
      if (odd) begin
         r.data[7:0] = b;
         r.be        = r.be | BE_LO;
      end else begin
         r.data[15:8] = b;
         r.be         = r.be | BE_HI;
      end
      return r;
   endfunction

endpackage

// File: rtl/bubsysrom_ioctl_loader_fifo.sv
// Synchronous word FIFO between the byte packer and the SDRAM writer.
//  clk_i/rst_ni : clock, asynchronous active-low reset
//  push_i/push_data_i : write one entry (ignored when full)
//  pop_i  : drop the head entry (ignored when empty)
//  head_o : current head entry (valid when !empty_o)
//  full_o/empty_o/free_o : occupancy status; free_o = DEPTH - count
module bubsysrom_ioctl_loader_fifo #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    free_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == CW'(0));
   assign free_o    = CW'(DEPTH) - count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/bubsysrom_ioctl_loader.sv
// BubSysROM ioctl ROM loader: packs the HPS download byte stream into big-endian
// 16-bit words and writes them to SDRAM over a req/ack word port.
//  i_EMU_MCLK / i_EMU_RST_n : core clock, asynchronous active-low reset
//  i_IOCTL_*                : MiSTer ioctl download bus (index, session, byte addr/data/strobe)
//  o_IOCTL_WAIT             : registered stall request back to the HPS
//  o_SDRAM_WR_*/i_SDRAM_WR_ACK : word write port; ADDR/DATA/BE stable while REQ is high
//  o_DOWNLOAD_DONE          : every byte of the session has been acknowledged by SDRAM
//  o_OVERFLOW               : sticky, a byte was dropped because the FIFO was full
module bubsysrom_ioctl_loader
   import bubsysrom_ioctl_loader_pkg::*;
#(
   parameter logic [IOCTL_INDEX_W-1:0] ROM_INDEX  = 16'h0000,
   parameter logic [WADDR_W-1:0]       BASE_WADDR = 24'h000000,
   parameter int                       FIFO_DEPTH = 8
) (
   input  logic                     i_EMU_MCLK,
   input  logic                     i_EMU_RST_n,
   input  logic [IOCTL_INDEX_W-1:0] i_IOCTL_INDEX,
   input  logic                     i_IOCTL_DOWNLOAD,
   input  logic [IOCTL_ADDR_W-1:0]  i_IOCTL_ADDR,
   input  logic [IOCTL_DATA_W-1:0]  i_IOCTL_DATA,
   input  logic                     i_IOCTL_WR,
   output logic                     o_IOCTL_WAIT,
   output logic                     o_SDRAM_WR_REQ,
   output logic [WADDR_W-1:0]       o_SDRAM_WR_ADDR,
   output logic [WDATA_W-1:0]       o_SDRAM_WR_DATA,
   output logic [1:0]               o_SDRAM_WR_BE,
   input  logic                     i_SDRAM_WR_ACK,
   output logic                     o_DOWNLOAD_DONE,
   output logic                     o_OVERFLOW
);

   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   // One cycle of WAIT latency plus one byte already on the bus needs two spare slots.
   localparam logic [CW-1:0] WAIT_FREE = CW'(2);

   session_e            sess_q;
   writer_e             wst_q;
   logic                dl_prev_q;
   logic                held_vld_q, held_vld_d;
   wentry_t             held_q, held_d;
   wentry_t             merged_s, push_data_s, head_s;
   logic [WENTRY_W-1:0] head_raw_s;
   logic [WADDR_W-1:0]  waddr_s;
   logic                push_s, pop_s, drop_s;
   logic                full_s, empty_s;
   logic [CW-1:0]       free_s;
   logic                dl_rise_s, dl_fall_s, idx_ok_s, wait_d;
   logic                req_q, wait_q, done_q, ovf_q;
   logic [WADDR_W-1:0]  addr_q;
   logic [WDATA_W-1:0]  data_q;
   logic [1:0]          be_q;
   logic                unused_addr_s;

   // Byte address bits above the 16 MiB word window do not map anywhere.
   assign unused_addr_s = ^i_IOCTL_ADDR[26:25];

   assign waddr_s   = BASE_WADDR + i_IOCTL_ADDR[24:1];
   assign dl_rise_s = i_IOCTL_DOWNLOAD & ~dl_prev_q;
   assign dl_fall_s = ~i_IOCTL_DOWNLOAD & dl_prev_q;
   assign idx_ok_s  = (i_IOCTL_INDEX == ROM_INDEX);
   assign pop_s     = (wst_q == W_REQ) & i_SDRAM_WR_ACK;
   assign head_s    = head_raw_s;

   // Byte packer: merge bytes into the holding word, push it when complete, when the
   // stream jumps to another word, or when a session ends with a partial word.
   always_comb begin
      held_d      = held_q;
      held_vld_d  = held_vld_q;
      push_s      = 1'b0;
      push_data_s = held_q;
      drop_s      = 1'b0;
      merged_s    = held_vld_q ? held_q : '{addr: waddr_s, data: 16'h0000, be: BE_NONE};
      merged_s    = lane_merge(merged_s, i_IOCTL_DATA, i_IOCTL_ADDR[0]);
      if ((sess_q == S_LOAD) && i_IOCTL_WR) begin
         if (full_s) begin
            drop_s = 1'b1;
         end else if (held_vld_q && (held_q.addr != waddr_s)) begin
            push_s      = 1'b1;
            push_data_s = held_q;
            held_d      = lane_merge('{addr: waddr_s, data: 16'h0000, be: BE_NONE},
                                     i_IOCTL_DATA, i_IOCTL_ADDR[0]);
            held_vld_d  = 1'b1;
         end else if (merged_s.be == BE_BOTH) begin
            push_s      = 1'b1;
            push_data_s = merged_s;
            held_d      = merged_s;
            held_vld_d  = 1'b0;
         end else begin
            held_d     = merged_s;
            held_vld_d = 1'b1;
         end
      end else if ((sess_q == S_DRAIN) && held_vld_q && !full_s) begin
         push_s      = 1'b1;
         push_data_s = held_q;
         held_vld_d  = 1'b0;
      end else begin
         held_vld_d = held_vld_q;
      end
   end

   // Next WAIT level: throttle near full while loading, and while a drain flush is pending.
   always_comb begin
      wait_d = 1'b0;
      if (sess_q == S_LOAD) begin
         wait_d = (free_s <= WAIT_FREE);
      end else if (sess_q == S_DRAIN) begin
         wait_d = held_vld_q;
      end else begin
         wait_d = 1'b0;
      end
   end

   // Holding register.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         held_q     <= '0;
         held_vld_q <= 1'b0;
      end else begin
         held_q     <= held_d;
         held_vld_q <= held_vld_d;
      end
   end

   // Session FSM with its registered WAIT/DONE/OVERFLOW outputs.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         sess_q    <= S_IDLE;
         dl_prev_q <= 1'b0;
         wait_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         dl_prev_q <= i_IOCTL_DOWNLOAD;
         wait_q    <= wait_d;
         case (sess_q)
            S_IDLE, S_DONE: begin
               if (dl_rise_s && idx_ok_s) begin
                  sess_q <= S_LOAD;
                  done_q <= 1'b0;
                  ovf_q  <= 1'b0;
               end
            end
            S_LOAD: begin
               if (drop_s)    ovf_q  <= 1'b1;
               if (dl_fall_s) sess_q <= S_DRAIN;
            end
            S_DRAIN: begin
               // Done only once nothing is held, queued or in flight to SDRAM.
               if (!held_vld_q && empty_s && (wst_q == W_IDLE)) begin
                  sess_q <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            default: sess_q <= S_IDLE;
         endcase
      end
   end

   // SDRAM writer FSM: present the FIFO head, hold it until ACK, then drop REQ for a cycle.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         wst_q  <= W_IDLE;
         req_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         be_q   <= '0;
      end else begin
         case (wst_q)
            W_IDLE: begin
               if (!empty_s) begin
                  addr_q <= head_s.addr;
                  data_q <= head_s.data;
                  be_q   <= head_s.be;
                  req_q  <= 1'b1;
                  wst_q  <= W_REQ;
               end
            end
            W_REQ: begin
               if (i_SDRAM_WR_ACK) begin
                  req_q <= 1'b0;
                  wst_q <= W_IDLE;
               end
            end
            default: begin
               req_q <= 1'b0;
               wst_q <= W_IDLE;
            end
         endcase
      end
   end

   bubsysrom_ioctl_loader_fifo #(
      .WIDTH (WENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (i_EMU_MCLK),
      .rst_ni      (i_EMU_RST_n),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .head_o      (head_raw_s),
      .full_o      (full_s),
      .empty_o     (empty_s),
      .free_o      (free_s)
   );

   assign o_IOCTL_WAIT    = wait_q;
   assign o_SDRAM_WR_REQ  = req_q;
   assign o_SDRAM_WR_ADDR = addr_q;
   assign o_SDRAM_WR_DATA = data_q;
   assign o_SDRAM_WR_BE   = be_q;
   assign o_DOWNLOAD_DONE = done_q;
   assign o_OVERFLOW      = ovf_q;

endmodule

// File: tb/tb_bubsysrom_ioctl_loader.sv
// Self-checking bench for bubsysrom_ioctl_loader: a byte-level model predicts the
// SDRAM word writes; a negedge monitor compares every write and per-cycle status.
module tb_bubsysrom_ioctl_loader;

   localparam logic [23:0] BASE = 24'h100000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] idx;
   logic        dl;
   logic [26:0] ioaddr;
   logic [7:0]  iodata;
   logic        wr;
   logic        wait_o, req_o, ack, done_o, ovf_o;
   logic [23:0] waddr_o;
   logic [15:0] wdata_o;
   logic [1:0]  be_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [41:0] exp_q [$];
   logic [41:0] got_q [$];
   logic        pend_vld = 1'b0;
   logic [23:0] pend_addr;
   logic [15:0] pend_data;
   logic [1:0]  pend_be;

   bit in_sess = 1'b0;
   bit chk_done_low = 1'b0;
   bit wait_seen = 1'b0;
   bit spur_en = 1'b0;
   int ack_lat = 3;
   bit rand_lat = 1'b0;

   bubsysrom_ioctl_loader #(
      .ROM_INDEX  (16'h0000),
      .BASE_WADDR (BASE),
      .FIFO_DEPTH (8)
   ) dut (
      .i_EMU_MCLK       (clk),
      .i_EMU_RST_n      (rst_n),
      .i_IOCTL_INDEX    (idx),
      .i_IOCTL_DOWNLOAD (dl),
      .i_IOCTL_ADDR     (ioaddr),
      .i_IOCTL_DATA     (iodata),
      .i_IOCTL_WR       (wr),
      .o_IOCTL_WAIT     (wait_o),
      .o_SDRAM_WR_REQ   (req_o),
      .o_SDRAM_WR_ADDR  (waddr_o),
      .o_SDRAM_WR_DATA  (wdata_o),
      .o_SDRAM_WR_BE    (be_o),
      .i_SDRAM_WR_ACK   (ack),
      .o_DOWNLOAD_DONE  (done_o),
      .o_OVERFLOW       (ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [41:0] got, input logic [41:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // Model: a ROM byte lands in the word BASE + byte_addr/2 (24-bit wrap), even byte high.
   // A word goes out when both bytes are present, when the stream moves to another word,
   // or (partially) when the session ends.
   task automatic model_byte(input logic [26:0] a, input logic [7:0] d);
      logic [23:0] wa;
      wa = BASE + a[24:1];
      if (pend_vld && pend_addr != wa) begin
         exp_q.push_back({pend_addr, pend_data, pend_be});
         pend_vld = 1'b0;
      end
      if (!pend_vld) begin
         pend_vld = 1'b1; pend_addr = wa; pend_data = 16'h0000; pend_be = 2'b00;
      end
      if (a[0]) begin pend_data[7:0] = d;  pend_be[0] = 1'b1; end
      else      begin pend_data[15:8] = d; pend_be[1] = 1'b1; end
      if (pend_be == 2'b11) begin
         exp_q.push_back({pend_addr, pend_data, pend_be});
         pend_vld = 1'b0;
      end
   endtask

   task automatic model_flush();
      if (pend_vld) exp_q.push_back({pend_addr, pend_data, pend_be});
      pend_vld = 1'b0;
   endtask

   // SDRAM responder: ACK after ack_lat cycles of REQ; optional spurious ACKs while idle.
   initial begin : ack_proc
      int cnt;
      cnt = 0;
      ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         ack = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else if (req_o) begin
            if (cnt >= ack_lat) begin
               ack = 1'b1;
               cnt = 0;
               if (rand_lat) ack_lat = $urandom_range(0, 4);
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
            if (spur_en && $urandom_range(0, 5) == 0) ack = 1'b1;
         end
      end
   end

   // Output monitor: every new write against the model, held-stable checks, status checks.
   initial begin : monitor
      logic        req_prev;
      logic [41:0] cur, held, e;
      req_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            req_prev = 1'b0;
         end else begin
            cur = {waddr_o, wdata_o, be_o};
            if (req_o && !req_prev) begin
               got_q.push_back(cur);
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL write_unexpected: got %h, required no write", cur);
               end else begin
                  e = exp_q.pop_front();
                  check("write", cur, e);
               end
               held = cur;
            end else if (req_o) begin
               check("write_stable", cur, held);
            end
            check("overflow", {41'd0, ovf_o}, 42'd0);
            if (!in_sess) check("wait_idle", {41'd0, wait_o}, 42'd0);
            if (chk_done_low) check("done_in_session", {41'd0, done_o}, 42'd0);
            if (wait_o) wait_seen = 1'b1;
            req_prev = req_o;
         end
      end
   end

   task automatic send_byte(input logic [26:0] a, input logic [7:0] d, input bit acc);
      int guard;
      guard = 0;
      while (wait_o && guard < 1000) begin @(posedge clk); #1; guard++; end
      if (guard >= 1000) check("wait_timeout", 42'd1, 42'd0);
      ioaddr = a; iodata = d; wr = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
      if (acc) model_byte(a, d);
   endtask

   task automatic start_session(input logic [15:0] index, input bit match);
      @(posedge clk); #1;
      idx = index; dl = 1'b1; pend_vld = 1'b0;
      if (match) in_sess = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      if (match) begin
         check("done_cleared", {41'd0, done_o}, 42'd0);
         chk_done_low = 1'b1;
      end
   endtask

   task automatic end_session(input bit match);
      @(posedge clk); #1;
      dl = 1'b0;
      chk_done_low = 1'b0;
      if (match) model_flush();
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (!done_o && guard < 3000) begin @(posedge clk); #1; guard++; end
      check("done_set", {41'd0, done_o}, 42'd1);
      check("all_written", 42'(exp_q.size()), 42'd0);
      in_sess = 1'b0;
   endtask

   initial begin : main
      int g0, n;
      logic [26:0] a;
      rst_n = 1'b0; idx = 16'h0000; dl = 1'b0; ioaddr = '0; iodata = '0; wr = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("reset_outputs", {req_o, wait_o, done_o, ovf_o, waddr_o, wdata_o, be_o}, 42'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Four sequential bytes -> two full words.
      ack_lat = 3;
      g0 = got_q.size();
      start_session(16'h0000, 1'b1);
      send_byte(27'd0, 8'h12, 1'b1); send_byte(27'd1, 8'h34, 1'b1);
      send_byte(27'd2, 8'h56, 1'b1); send_byte(27'd3, 8'h78, 1'b1);
      end_session(1'b1);
      wait_done();
      check("t1_count", 42'(got_q.size() - g0), 42'd2);
      if (got_q.size() >= g0 + 2) begin
         check("t1_w0", got_q[g0],     {24'h100000, 16'h1234, 2'b11});
         check("t1_w1", got_q[g0 + 1], {24'h100001, 16'h5678, 2'b11});
      end

      // Odd byte count -> partial high-lane word at drain.
      g0 = got_q.size();
      start_session(16'h0000, 1'b1);
      send_byte(27'd0, 8'hAA, 1'b1); send_byte(27'd1, 8'hBB, 1'b1); send_byte(27'd2, 8'hCC, 1'b1);
      end_session(1'b1);
      wait_done();
      check("t2_count", 42'(got_q.size() - g0), 42'd2);
      if (got_q.size() >= g0 + 2) begin
         check("t2_w0", got_q[g0],     {24'h100000, 16'hAABB, 2'b11});
         check("t2_w1", got_q[g0 + 1], {24'h100001, 16'hCC00, 2'b10});
      end

      // Non-sequential single bytes.
      g0 = got_q.size();
      start_session(16'h0000, 1'b1);
      send_byte(27'd5, 8'h11, 1'b1); send_byte(27'd8, 8'h22, 1'b1);
      end_session(1'b1);
      wait_done();
      check("t5_count", 42'(got_q.size() - g0), 42'd2);
      if (got_q.size() >= g0 + 2) begin
         check("t5_w0", got_q[g0],     {24'h100002, 16'h0011, 2'b01});
         check("t5_w1", got_q[g0 + 1], {24'h100004, 16'h2200, 2'b10});
      end

      // Foreign index: ignored entirely, DONE from the previous session kept.
      g0 = got_q.size();
      start_session(16'h0001, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(27'(i), 8'(i + 8'h40), 1'b0);
      end_session(1'b0);
      repeat (20) @(posedge clk); #1;
      check("t4_no_write", 42'(got_q.size() - g0), 42'd0);
      check("t4_done_kept", {41'd0, done_o}, 42'd1);

      // ACK held off: WAIT must throttle the stream with no loss.
      ack_lat = 40; wait_seen = 1'b0;
      start_session(16'h0000, 1'b1);
      for (int i = 0; i < 40; i++) send_byte(27'(16'h0200 + i), 8'($urandom), 1'b1);
      end_session(1'b1);
      wait_done();
      check("t3_wait_seen", {41'd0, wait_seen}, 42'd1);

      // Randomized sessions: jumps, lane overwrites, wrap past the top of SDRAM, spurious ACKs.
      rand_lat = 1'b1; ack_lat = 1; spur_en = 1'b1;
      for (int s = 0; s < 5; s++) begin
         start_session(16'h0000, 1'b1);
         a = ($urandom_range(0, 3) == 0) ? 27'h1FFFFF8 : 27'($urandom);
         n = $urandom_range(20, 60);
         for (int i = 0; i < n; i++) begin
            send_byte(a, 8'($urandom), 1'b1);
            case ($urandom_range(0, 11))
               0:       a = 27'($urandom);
               1:       a = a;
               2:       a = a + 27'd3;
               default: a = a + 27'd1;
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         end_session(1'b1);
         wait_done();
      end
      rand_lat = 1'b0; spur_en = 1'b0;

      // Reset while REQ is high, then a clean session.
      ack_lat = 30;
      start_session(16'h0000, 1'b1);
      for (int i = 0; i < 6; i++) send_byte(27'(i + 27'h40), 8'(i + 8'h90), 1'b1);
      begin : wait_req
         int guard;
         guard = 0;
         while (!req_o && guard < 100) begin @(posedge clk); #1; guard++; end
         check("t6_req_high", {41'd0, req_o}, 42'd1);
      end
      rst_n = 1'b0; dl = 1'b0; in_sess = 1'b0; chk_done_low = 1'b0;
      #1;
      check("t6_reset_outputs", {req_o, wait_o, done_o, ovf_o, waddr_o, wdata_o, be_o}, 42'd0);
      exp_q.delete(); pend_vld = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      ack_lat = 2;
      repeat (2) @(posedge clk); #1;
      g0 = got_q.size();
      start_session(16'h0000, 1'b1);
      send_byte(27'd10, 8'hDE, 1'b1); send_byte(27'd11, 8'hAD, 1'b1);
      end_session(1'b1);
      wait_done();
      check("t6_count", 42'(got_q.size() - g0), 42'd1);
      if (got_q.size() >= g0 + 1) check("t6_w0", got_q[g0], {24'h100005, 16'hDEAD, 2'b11});

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
